dsp_vec_unit: RTL and testbench
===============================

DSP_VEC_UNIT -- requirements
Module: dsp_vec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, element width in bits.
REQ-002 SHALL have parameter N, default 8, vector length and output count.
REQ-003 SHALL have parameter TAPS, default 8, FIR coefficient count; elaboration error if TAPS > N or TAPS < 1.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, request; sampled only in IDLE.
REQ-007 SHALL have port op, input, 2, operation: 00 add, 01 mul, 11 sub, 10 FIR.
REQ-008 SHALL have port a, input, N*WIDTH, element i at bits [i*WIDTH +: WIDTH]; FIR coefficients h[j] = a[j], j < TAPS.
REQ-009 SHALL have port b, input, N*WIDTH, same packing; FIR signal x[i] = b[i].
REQ-010 SHALL have port result, output, N*WIDTH, registered, same packing.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-012 SHALL have port done, output, 1, registered one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM IDLE -> LOAD (start=1) -> EXEC -> DRAIN (FIR only) -> DONE -> IDLE.
REQ-014 SHALL, in LOAD, capture a, b and op into internal registers; input changes after capture have no effect.
REQ-015 SHALL, for add/sub/mul, process one element per EXEC cycle, index 0..N-1, writing result[i] as the low WIDTH bits of a[i] op b[i].
REQ-016 SHALL, for FIR, compute y[n] = sum over j = 0..TAPS-1 of h[j]*x[n-j], with x[m] = 0 for m < 0, for n = 0..N-1.
REQ-017 SHALL perform FIR with one multiplier: one product per EXEC cycle into a registered product stage, accumulated the following cycle, N*TAPS EXEC cycles, plus one DRAIN cycle.
REQ-018 SHALL write result[n] when its last product is accumulated, then clear the accumulator without losing the in-flight product of n+1.
REQ-019 SHALL pulse done for exactly one cycle, DONE -> IDLE.
REQ-020 SHALL assert done at edge E+N+2 for elementwise and E+N*TAPS+3 for FIR, where E is the edge sampling start=1.
REQ-021 SHALL keep result stable from done until the next LOAD.
REQ-022 SHALL ignore start while busy=1, including in the DONE cycle.
REQ-023 SHALL default to wraparound modulo 2^WIDTH; FIR accumulator is WIDTH bits.
REQ-024 SHALL treat operands as two's-complement signed for mul and FIR.

Reset
REQ-025 SHALL, on rst_n=0, immediately force state=IDLE, result=0, done=0, busy=0, and clear counters, accumulator and product register, including mid-operation.
REQ-026 SHALL accept a new start on the first edge after rst_n deasserts.

Configuration
REQ-027 SHALL, when DSP_SAT_EN is defined, saturate add/sub/mul results to the signed WIDTH range.
REQ-028 SHALL, when DSP_SAT_EN is defined, use a 2*WIDTH+$clog2(TAPS) bit FIR accumulator, saturating to signed WIDTH only when writing result.
REQ-029 SHALL, when DSP_SAT_EN is undefined, use pure wraparound per REQ-023, with unchanged latency.

Structure
REQ-030 SHALL place op encoding enum, FSM state enum and a saturate function in package dsp_pkg.
REQ-031 SHALL instantiate one combinational sub-module, dsp_alu, containing add/sub/mul and optional saturation, shared by all modes.

Verification (WIDTH=32, N=8, TAPS=8)
REQ-032 SHALL cover: add, a[i]=i, b[i]=10*i -> result[i]=11*i; done at E+10, high exactly one cycle.
REQ-033 SHALL cover: sub, a[0]=0x80000000, b[0]=1 -> result[0]=0x7FFFFFFF without DSP_SAT_EN, 0x80000000 with it.
REQ-034 SHALL cover: FIR impulse, h={1,2,3,4,5,6,7,8}, x={1,0,0,0,0,0,0,0} -> result={1,2,3,4,5,6,7,8}; done at E+67.
REQ-035 SHALL cover: FIR step, h all 1, x all 1 -> result={1,2,3,4,5,6,7,8}; then h all 0x7FFFFFFF, x all 2 -> result[7] wraps without DSP_SAT_EN and saturates to 0x7FFFFFFF with it.
REQ-036 SHALL cover: start re-pulsed at E+5 and in the DONE cycle -> ignored, one done only; a and b changed at E+3 -> no effect on result.
REQ-037 SHALL cover: rst_n low at E+20 of FIR -> result=0, done=0, busy=0 immediately; a subsequent add run is correct.

Source files
------------

// File: rtl/dsp_pkg.sv
// -----------------------------------------------------------------------------
// dsp_pkg -- shared definitions for the vector DSP unit.
//
// Contents:
//   dsp_op_e    : operation encoding carried on the 2-bit op port
//   dsp_state_e : control FSM state encoding
//   SAT_W       : widest value the saturate helper accepts
//   saturate()  : clamp a signed value to the signed range of a w-bit word
// -----------------------------------------------------------------------------
package dsp_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_FIR = 2'b10,
    OP_SUB = 2'b11
  } dsp_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EXEC  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } dsp_state_e;

  // Callers sign-extend their operand to SAT_W bits and keep the low w bits
  // of the returned value.
  localparam int SAT_W = 256;

  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic [SAT_W-1:0]        ones;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    ones  = '1;
    max_v = signed'(ones >> (SAT_W + 1 - w));
    min_v = ~max_v;
    if (v > max_v) begin
      return max_v;
    end
    if (v < min_v) begin
      return min_v;
    end
    return v;
  endfunction

endpackage

// File: rtl/dsp_alu.sv
// -----------------------------------------------------------------------------
// dsp_alu -- combinational add / sub / mul shared by every mode of the
// vector unit. Elementwise modes use res; FIR uses the product output.
//
// Optional feature macro: DSP_SAT_EN
//   defined   : res saturates to the signed WIDTH range, prod is full width
//   undefined : res wraps modulo 2^WIDTH, prod is the low WIDTH bits
//
// Parameters:
//   WIDTH  : operand / result width
//   PROD_W : product width (2*WIDTH with DSP_SAT_EN, WIDTH otherwise)
// Ports:
//   x, y : signed operands
//   op   : operation (OP_FIR is treated as a multiply)
//   res  : WIDTH-bit result of x op y
//   prod : signed product x*y, PROD_W bits
// -----------------------------------------------------------------------------
module dsp_alu
  import dsp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PROD_W = WIDTH
) (
  input  logic signed [WIDTH-1:0]  x,
  input  logic signed [WIDTH-1:0]  y,
  input  dsp_op_e                  op,
  output logic signed [WIDTH-1:0]  res,
  output logic signed [PROD_W-1:0] prod
);

`ifdef DSP_SAT_EN
  logic signed [WIDTH:0] sum_w;
  logic signed [WIDTH:0] dif_w;

  always_comb begin
    sum_w = (WIDTH+1)'(x) + (WIDTH+1)'(y);
    dif_w = (WIDTH+1)'(x) - (WIDTH+1)'(y);
    prod  = PROD_W'(x) * PROD_W'(y);
    case (op)
      OP_ADD:  res = WIDTH'(saturate(SAT_W'(sum_w), WIDTH));
      OP_SUB:  res = WIDTH'(saturate(SAT_W'(dif_w), WIDTH));
      default: res = WIDTH'(saturate(SAT_W'(prod), WIDTH));
    endcase
  end
`else
  always_comb begin
    prod = PROD_W'(x) * PROD_W'(y);
    case (op)
      OP_ADD:  res = x + y;
      OP_SUB:  res = x - y;
      default: res = prod[WIDTH-1:0];
    endcase
  end
`endif

endmodule

// File: rtl/dsp_vec_unit.sv
// -----------------------------------------------------------------------------
// dsp_vec_unit -- N-element vector unit: elementwise add / sub / mul, or a
// TAPS-tap FIR over the vector using a single multiplier.
//
// Optional feature macro: DSP_SAT_EN
//   defined   : elementwise results saturate; FIR accumulates at
//               2*WIDTH+clog2(TAPS) bits and saturates when writing result
//   undefined : everything wraps modulo 2^WIDTH (WIDTH-bit FIR accumulator)
//   Latency is identical in both builds.
//
// Parameters: WIDTH (element bits), N (vector length), TAPS (FIR taps, 1..N)
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : run request, sampled only in IDLE
//   op     : 00 add, 01 mul, 11 sub, 10 FIR
//   a      : element i at [i*WIDTH +: WIDTH]; FIR coefficients h[j] = a[j]
//   b      : same packing; FIR signal x[i] = b[i]
//   result : registered output vector, same packing
//   busy   : high in every state except IDLE
//   done   : registered one-cycle completion pulse on leaving DONE
// -----------------------------------------------------------------------------
module dsp_vec_unit
  import dsp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int TAPS  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [N*WIDTH-1:0] a,
  input  logic [N*WIDTH-1:0] b,
  output logic [N*WIDTH-1:0] result,
  output logic               busy,
  output logic               done
);

`ifdef DSP_SAT_EN
  localparam int PROD_W = 2 * WIDTH;
  localparam int ACC_W  = 2 * WIDTH + $clog2(TAPS);
`else
  localparam int PROD_W = WIDTH;
  localparam int ACC_W  = WIDTH;
`endif

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IDX_W-1:0] ELEM_LAST = IDX_W'(N - 1);
  localparam logic [TAP_W-1:0] TAP_LAST  = TAP_W'(TAPS - 1);

  if (TAPS > N || TAPS < 1) begin : g_bad_taps
    $error("dsp_vec_unit: TAPS must lie in 1..N");
  end

`ifdef DSP_SAT_EN
  if (ACC_W > SAT_W) begin : g_bad_width
    $error("dsp_vec_unit: accumulator wider than the saturate helper");
  end
`endif

  dsp_state_e state;
  dsp_state_e state_nxt;

  dsp_op_e            op_r;
  logic [N*WIDTH-1:0] a_r;
  logic [N*WIDTH-1:0] b_r;
  logic [IDX_W-1:0]   elem_idx;
  logic [TAP_W-1:0]   tap_idx;

  dsp_op_e                  alu_op;
  logic signed [WIDTH-1:0]  x_sel;
  logic signed [WIDTH-1:0]  y_sel;
  logic signed [WIDTH-1:0]  alu_res;
  logic signed [PROD_W-1:0] alu_prod;

  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;
  logic                     last_p1;
  logic [IDX_W-1:0]         oidx_p1;

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;

  function automatic logic [WIDTH-1:0] acc_to_res(input logic signed [ACC_W-1:0] v);
`ifdef DSP_SAT_EN
    return WIDTH'(saturate(SAT_W'(v), WIDTH));
`else
    return WIDTH'(v);
`endif
  endfunction

  assign busy = (state != S_IDLE);

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: state_nxt = S_EXEC;
      S_EXEC: begin
        if (op_r == OP_FIR) begin
          if (elem_idx == ELEM_LAST && tap_idx == TAP_LAST) begin
            state_nxt = S_DRAIN;
          end
        end else if (elem_idx == ELEM_LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand select. FIR reads h[j] and x[n-j]; taps reaching before x[0]
  // see zero so the leading outputs need no special case.
  always_comb begin
    alu_op = op_r;
    x_sel  = '0;
    y_sel  = '0;
    if (op_r == OP_FIR) begin
      alu_op = OP_MUL;
      x_sel  = a_r[tap_idx*WIDTH +: WIDTH];
      if (elem_idx >= IDX_W'(tap_idx)) begin
        y_sel = b_r[(elem_idx - IDX_W'(tap_idx))*WIDTH +: WIDTH];
      end
    end else begin
      x_sel = a_r[elem_idx*WIDTH +: WIDTH];
      y_sel = b_r[elem_idx*WIDTH +: WIDTH];
    end
  end

  dsp_alu #(
    .WIDTH  (WIDTH),
    .PROD_W (PROD_W)
  ) u_alu (
    .x    (x_sel),
    .y    (y_sel),
    .op   (alu_op),
    .res  (alu_res),
    .prod (alu_prod)
  );

  assign acc_sum = acc + ACC_W'(prod_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= OP_ADD;
      a_r      <= '0;
      b_r      <= '0;
      elem_idx <= '0;
      tap_idx  <= '0;
      prod_p1  <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      oidx_p1  <= '0;
      acc      <= '0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      done   <= (state == S_DONE);
      vld_p1 <= 1'b0;

      // Stage p0: operand capture, elementwise write-back, FIR product issue
      case (state)
        S_LOAD: begin
          op_r     <= dsp_op_e'(op);
          a_r      <= a;
          b_r      <= b;
          elem_idx <= '0;
          tap_idx  <= '0;
          acc      <= '0;
        end
        S_EXEC: begin
          if (op_r == OP_FIR) begin
            prod_p1 <= alu_prod;
            vld_p1  <= 1'b1;
            last_p1 <= (tap_idx == TAP_LAST);
            oidx_p1 <= elem_idx;
            if (tap_idx == TAP_LAST) begin
              tap_idx  <= '0;
              elem_idx <= elem_idx + IDX_W'(1);
            end else begin
              tap_idx <= tap_idx + TAP_W'(1);
            end
          end else begin
            result[elem_idx*WIDTH +: WIDTH] <= alu_res;
            elem_idx                        <= elem_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase

      // Stage p1: accumulate. On an output's last tap the sum goes straight
      // to result and acc restarts at zero; the next output's first product
      // is already held in prod_p1 and is added on the following cycle.
      if (vld_p1) begin
        if (last_p1) begin
          result[oidx_p1*WIDTH +: WIDTH] <= acc_to_res(acc_sum);
          acc                            <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_vec_unit.sv
`timescale 1ns/1ps
module tb_dsp_vec_unit;
  localparam int W       = 32;
  localparam int NN      = 8;
  localparam int TP      = 8;
  localparam int LAT_EW  = NN + 2;
  localparam int LAT_FIR = NN * TP + 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op    = 2'b00;
  logic [NN*W-1:0] a   = '0;
  logic [NN*W-1:0] b   = '0;
  logic [NN*W-1:0] result;
  logic          busy;
  logic          done;

  dsp_vec_unit #(.WIDTH(W), .N(NN), .TAPS(TP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NN*W-1:0] res;
    int              done_cyc;
    int              id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   run_id    = 0;
  bit   prev_done = 1'b0;

  logic [W-1:0] va [NN];
  logic [W-1:0] vb [NN];
  logic [W-1:0] ve [NN];

  // Monitor: every done pulse pops one expected run and compares it.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        n_checks++;
        if (prev_done) begin
          n_fail++;
          $display("FAIL done_pulse_width: done high again at cycle %0d, required a single-cycle pulse", cyc);
        end
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: done at cycle %0d, required no run outstanding to finish", cyc);
        end else begin
          mon_e = sb.pop_front();
          n_checks++;
          if (cyc != mon_e.done_cyc) begin
            n_fail++;
            $display("FAIL run%0d_done_cycle: done at cycle %0d, required %0d", mon_e.id, cyc, mon_e.done_cyc);
          end
          for (int i = 0; i < NN; i++) begin
            n_checks++;
            if (result[i*W +: W] !== mon_e.res[i*W +: W]) begin
              n_fail++;
              $display("FAIL run%0d_result[%0d]: got %h, required %h", mon_e.id, i, result[i*W +: W], mon_e.res[i*W +: W]);
            end
          end
        end
      end
      prev_done = rst_n && done;
    end
  end

  task automatic chk_vec(input string nm, input logic [NN*W-1:0] act, input logic [NN*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", nm, act, exp);
    end
  endtask

  // Drive one run from va/vb; push ve as the expected result when push=1.
  // Returns e = index of the edge that sampled start.
  task automatic launch(input logic [1:0] o, input int lat, input bit push, input bit sync, output int e);
    exp_t ent;
    if (sync) @(negedge clk);
    op = o;
    for (int i = 0; i < NN; i++) begin
      a[i*W +: W]       = va[i];
      b[i*W +: W]       = vb[i];
      ent.res[i*W +: W] = ve[i];
    end
    start = 1'b1;
    @(negedge clk);
    e     = cyc;
    start = 1'b0;
    if (push) begin
      ent.done_cyc = e + lat;
      ent.id       = run_id;
      sb.push_back(ent);
    end
    run_id++;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < budget);
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles (cycle %0d), required one", budget, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int e;

    // Reset state
    #3;
    chk_vec("reset_result", result, '0);
    chk_bit("reset_done", done, 1'b0);
    chk_bit("reset_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add: a[i]=i, b[i]=10i -> 11i
    for (int i = 0; i < NN; i++) begin
      va[i] = i; vb[i] = 10 * i; ve[i] = 11 * i;
    end
    launch(2'b00, LAT_EW, 1'b1, 1'b1, e);
    wait_done(40);

    // Sub with the most-negative operand
    for (int i = 0; i < NN; i++) begin
      va[i] = i + 5; vb[i] = 3; ve[i] = i + 2;
    end
    va[0] = 32'h8000_0000; vb[0] = 32'h1;
`ifdef DSP_SAT_EN
    ve[0] = 32'h8000_0000;
`else
    ve[0] = 32'h7FFF_FFFF;
`endif
    launch(2'b11, LAT_EW, 1'b1, 1'b1, e);
    wait_done(40);

    // Signed mul, including an overflowing product
    for (int i = 0; i < NN; i++) begin
      va[i] = i - 4; vb[i] = 3; ve[i] = 3 * (i - 4);
    end
    va[1] = -3; vb[1] = -5; ve[1] = 15;
    va[7] = 32'h0001_0000; vb[7] = 32'h0001_0000;
`ifdef DSP_SAT_EN
    ve[7] = 32'h7FFF_FFFF;
`else
    ve[7] = 32'h0;
`endif
    launch(2'b01, LAT_EW, 1'b1, 1'b1, e);
    wait_done(40);

    // FIR impulse response
    for (int i = 0; i < NN; i++) begin
      va[i] = i + 1; vb[i] = (i == 0) ? 1 : 0; ve[i] = i + 1;
    end
    launch(2'b10, LAT_FIR, 1'b1, 1'b1, e);
    wait_done(100);

    // FIR step response
    for (int i = 0; i < NN; i++) begin
      va[i] = 1; vb[i] = 1; ve[i] = i + 1;
    end
    launch(2'b10, LAT_FIR, 1'b1, 1'b1, e);
    wait_done(100);

    // FIR overflow: y[n] = (n+1) * 2 * 0x7FFFFFFF
    for (int i = 0; i < NN; i++) begin
      va[i] = 32'h7FFF_FFFF; vb[i] = 2;
`ifdef DSP_SAT_EN
      ve[i] = 32'h7FFF_FFFF;
`else
      ve[i] = -2 * (i + 1);
`endif
    end
    launch(2'b10, LAT_FIR, 1'b1, 1'b1, e);
    wait_done(100);

    // Inputs changed after capture and start re-pulsed while busy
    for (int i = 0; i < NN; i++) begin
      va[i] = 2 * i + 1; vb[i] = i; ve[i] = 3 * i + 1;
    end
    launch(2'b00, LAT_EW, 1'b1, 1'b1, e);
    wait_cyc(e + 3);
    chk_bit("busy_mid_run", busy, 1'b1);
    a = '1;
    b = '1;
    wait_cyc(e + 4);
    start = 1'b1;
    wait_cyc(e + 5);
    start = 1'b0;
    wait_cyc(e + LAT_EW - 1);
    start = 1'b1;
    wait_cyc(e + LAT_EW);
    start = 1'b0;
    wait_cyc(e + LAT_EW + 2);
    chk_bit("busy_after_ignored_start", busy, 1'b0);
    wait_cyc(e + LAT_EW + 20);

    // Reset in the middle of a FIR run, then an add straight after release
    for (int i = 0; i < NN; i++) begin
      va[i] = i + 1; vb[i] = 1; ve[i] = 0;
    end
    launch(2'b10, LAT_FIR, 1'b0, 1'b1, e);
    wait_cyc(e + 20);
    chk_bit("busy_before_abort", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_vec("abort_result", result, '0);
    chk_bit("abort_done", done, 1'b0);
    chk_bit("abort_busy", busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NN; i++) begin
      va[i] = 100 + i; vb[i] = i; ve[i] = 100 + 2 * i;
    end
    launch(2'b00, LAT_EW, 1'b1, 1'b0, e);
    wait_done(40);

    repeat (30) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d runs never completed, required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
